// File: rtl/stepper_if.sv
// stepper_if: host command, status and coil-drive bundle for stepper_sequencer
interface stepper_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int STEP_WIDTH = 16,
  parameter int POS_WIDTH  = 24
);
  logic                  motor_enable;
  logic                  hold;
  logic                  half_step;
  logic [DIV_WIDTH-1:0]  step_period;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [STEP_WIDTH-1:0] cmd_steps;
  logic                  abort;
  logic [3:0]            coils;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [POS_WIDTH-1:0]  position;
  logic [2:0]            phase;
  modport master (
    output motor_enable, hold, half_step, step_period, cmd_valid, cmd_dir, cmd_steps, abort,
    input  cmd_ready, coils, busy, done, aborted, position, phase
  );
  modport slave (
    input  motor_enable, hold, half_step, step_period, cmd_valid, cmd_dir, cmd_steps, abort,
    output cmd_ready, coils, busy, done, aborted, position, phase
  );
endinterface

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: counted half/full-step moves at a programmable rate with abort and position tracking
module stepper_sequencer #(
  parameter int DIV_WIDTH  = 16,
  parameter int STEP_WIDTH = 16,
  parameter int POS_WIDTH  = 24
) (
  input logic      clk,
  input logic      rst,
  stepper_if.slave s
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [31:0] TBL = 32'h98C46231;
  logic [0:0]            state, state_n;
  logic                  dir_q, half_q, fin, fin_ab;
  logic                  accept, stop, tick, last;
  logic [DIV_WIDTH-1:0]  per_q, per_n, div;
  logic [STEP_WIDTH-1:0] left;
  logic [2:0]            phase, phase_n, inc;
  logic [POS_WIDTH-1:0]  pos, pos_n, pinc;
  assign s.cmd_ready = state == IDLE && s.motor_enable;
  assign s.busy      = state == RUN;
  assign s.phase     = phase;
  assign s.position  = pos;
  always_comb begin
    accept  = s.cmd_ready && s.cmd_valid;
    stop    = state == RUN && (s.abort || !s.motor_enable);
    tick    = state == RUN && !stop && div == '0;
    last    = tick && left == STEP_WIDTH'(1);
    per_n   = s.step_period == '0 ? DIV_WIDTH'(1) : s.step_period;
    inc     = {1'b0, ~half_q, half_q};
    pinc    = {{(POS_WIDTH-2){1'b0}}, ~half_q, half_q};
    phase_n = !tick ? phase : dir_q ? phase + inc : phase - inc;
    pos_n   = !tick ? pos : dir_q ? pos + pinc : pos - pinc;
    state_n = (accept && s.cmd_steps != '0) ? RUN : (stop || last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      per_q     <= '0;
      div       <= '0;
      left      <= '0;
      phase     <= '0;
      pos       <= '0;
      fin       <= 1'b0;
      fin_ab    <= 1'b0;
      s.coils   <= 4'b0000;
      s.done    <= 1'b0;
      s.aborted <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      pos       <= pos_n;
      // the final step still drives its pattern even though the FSM is leaving RUN
      s.coils   <= (s.motor_enable && (state_n == RUN || tick || s.hold)) ? TBL[{phase_n, 2'b00} +: 4] : 4'b0000;
      fin       <= (accept && s.cmd_steps == '0) || stop || last;
      fin_ab    <= stop;
      s.done    <= fin;
      s.aborted <= fin_ab;
      if (accept) begin
        dir_q  <= s.cmd_dir;
        half_q <= s.half_step;
        per_q  <= per_n;
        div    <= per_n - DIV_WIDTH'(1);
        left   <= s.cmd_steps;
      end else if (tick) begin
        div  <= per_q - DIV_WIDTH'(1);
        left <= left - STEP_WIDTH'(1);
      end else if (state == RUN) begin
        div <= div - DIV_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: randomized moves checked by a step/done scoreboard fed from a move-level model
module tb_stepper_sequencer;
  typedef struct {int cyc; int ph; int pos;} step_t;
  typedef struct {int cyc; bit ab; int ph; int pos;} done_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int mph = 0;
  int mpos = 0;
  int tbl [8] = '{1, 3, 2, 6, 4, 12, 8, 9};
  step_t steps_q [$];
  done_t done_q [$];
  stepper_if #(.DIV_WIDTH(16), .STEP_WIDTH(16), .POS_WIDTH(24)) s ();
  stepper_if #(.DIV_WIDTH(16), .STEP_WIDTH(16), .POS_WIDTH(4)) s2 ();
  stepper_sequencer #(.DIV_WIDTH(16), .STEP_WIDTH(16), .POS_WIDTH(24)) u_dut (.clk(clk), .rst(rst), .s(s));
  stepper_sequencer #(.DIV_WIDTH(16), .STEP_WIDTH(16), .POS_WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .s(s2));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic int wrap4(int v);
    return ((v + 8) % 16 + 16) % 16 - 8;
  endfunction
  initial begin
    int prev = 0;
    step_t e;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst) prev = int'(s.phase);
      else begin
        if (int'(s.phase) != prev) begin
          if (steps_q.size() == 0) chk("step_unexpected", s.phase, prev);
          else begin
            e = steps_q.pop_front();
            chk("step_cycle", cyc, e.cyc);
            chk("step_phase", s.phase, e.ph);
            chk("step_pos", int'($signed(s.position)), e.pos);
            chk("step_coils", s.coils, tbl[e.ph]);
          end
          prev = int'(s.phase);
        end
        if (s.done) begin
          if (done_q.size() == 0) chk("done_unexpected", s.done, 0);
          else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("done_aborted", s.aborted, d.ab);
            chk("done_phase", s.phase, d.ph);
            chk("done_pos", int'($signed(s.position)), d.pos);
          end
        end else chk("aborted_idle", s.aborted, 0);
      end
    end
  end
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mph = 0;
    mpos = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((done_q.size() != 0 || steps_q.size() != 0 || s.busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("idle_timeout", t, 0);
    @(posedge clk); #1;
  endtask
  task automatic issue(bit d, bit h, int n, int p, int a, bit via_en);
    int pe, st, m, acc;
    pe = p == 0 ? 1 : p;
    st = h ? 1 : 2;
    if (!d) st = -st;
    m = a > 0 ? (a - 1) / pe : n;
    acc = cyc + 1;
    chk("ready_before_cmd", s.cmd_ready, 1);
    for (int k = 1; k <= m; k++) begin
      mph = (mph + st + 8) % 8;
      mpos += st;
      steps_q.push_back('{acc + k * pe, mph, mpos});
    end
    done_q.push_back('{a > 0 ? acc + a + 1 : n == 0 ? acc + 1 : acc + n * pe + 1, a > 0, mph, mpos});
    s.cmd_dir = d;
    s.half_step = h;
    s.cmd_steps = 16'(n);
    s.step_period = 16'(p);
    s.cmd_valid = 1'b1;
    @(posedge clk); #1;
    s.cmd_valid = 1'b0;
    s.step_period = 16'($urandom);
    s.half_step = 1'($urandom);
    s.cmd_dir = 1'($urandom);
    s.cmd_steps = 16'($urandom);
    if (a > 0) begin
      repeat (a - 1) @(posedge clk);
      #1;
      if (via_en) s.motor_enable = 1'b0;
      else s.abort = 1'b1;
      @(posedge clk); #1;
      s.abort = 1'b0;
      if (via_en) begin
        @(negedge clk);
        chk("en_drop_coils", s.coils, 0);
        chk("en_drop_ready", s.cmd_ready, 0);
        repeat (3) begin
          @(negedge clk);
          chk("en_off_ready", s.cmd_ready, 0);
        end
        @(posedge clk); #1;
        s.motor_enable = 1'b1;
      end
    end
  endtask
  initial begin
    int cnt;
    s.motor_enable = 1'b1; s.hold = 1'b1; s.half_step = 1'b1; s.step_period = 16'd4;
    s.cmd_valid = 1'b0; s.cmd_dir = 1'b1; s.cmd_steps = 16'd0; s.abort = 1'b0;
    s2.motor_enable = 1'b1; s2.hold = 1'b1; s2.half_step = 1'b1; s2.step_period = 16'd0;
    s2.cmd_valid = 1'b0; s2.cmd_dir = 1'b1; s2.cmd_steps = 16'd0; s2.abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_coils", s.coils, 0);
    chk("rst_busy", s.busy, 0);
    chk("rst_done", s.done, 0);
    chk("rst_aborted", s.aborted, 0);
    chk("rst_position", s.position, 0);
    chk("rst_phase", s.phase, 0);
    chk("rst_ready", s.cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1, 1, 3, 4, 0, 0);
    wait_idle();
    chk("t1_position", int'($signed(s.position)), 3);
    chk("t1_phase", s.phase, 3);
    do_reset();
    issue(0, 0, 5, 2, 0, 0);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (s.busy) cnt++;
    end
    chk("t2_busy_cycles", cnt, 10);
    wait_idle();
    chk("t2_position", int'($signed(s.position)), -10);
    issue(1, 1, 0, 3, 0, 0);
    @(negedge clk);
    chk("t3_busy0", s.busy, 0);
    @(negedge clk);
    chk("t3_busy1", s.busy, 0);
    chk("t3_coils", s.coils, tbl[mph]);
    wait_idle();
    do_reset();
    issue(1, 1, 10, 3, 12, 0);
    wait_idle();
    chk("t4_position", int'($signed(s.position)), 3);
    issue(1, 1, 8, 2, 5, 1);
    wait_idle();
    s.hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hold0_coils", s.coils, 0);
    @(posedge clk); #1;
    s.hold = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold1_coils", s.coils, tbl[mph]);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      bit d, h;
      int n, p, pe, a;
      d = 1'($urandom);
      h = 1'($urandom);
      n = $urandom_range(0, 10);
      p = $urandom_range(0, 4);
      pe = p == 0 ? 1 : p;
      a = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * pe) : 0;
      s.hold = 1'($urandom);
      issue(d, h, n, p, a, 1'($urandom));
      wait_idle();
    end
    s2.cmd_steps = 16'd7;
    s2.cmd_valid = 1'b1;
    @(posedge clk); #1;
    s2.cmd_valid = 1'b0;
    s2.step_period = 16'd9;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      chk("p0_position", int'($signed(s2.position)), k);
    end
    repeat (2) @(posedge clk);
    #1;
    s2.cmd_steps = 16'd1;
    s2.step_period = 16'd0;
    s2.cmd_valid = 1'b1;
    @(posedge clk); #1;
    s2.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_position", int'($signed(s2.position)), wrap4(7 + 1));
    chk("wrap_phase", s2.phase, 0);
    chk("queues_drained", steps_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
